// File: rtl/dmem_pkg.sv
// Shared types, widths and request validation for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  localparam logic [WORD_W-1:0] RESET_RDATA_DEF = 32'h0;

  // A request is rejected when misaligned, beyond the array, or a store with no lanes.
  function automatic logic is_invalid(input logic [31:0]     addr,
                                      input logic            we,
                                      input logic [BE_W-1:0] be,
                                      input logic [31:0]     depth);
    logic [31:0] widx;
    widx = {2'b00, addr[31:2]};
    return (addr[1:0] != 2'b00) || (widx >= depth) || (we && (be == '0));
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word array with per-byte write lanes and a registered read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk_i,
  input  logic              en,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  // One narrow array per byte lane keeps each lane a plain inferred RAM.
  for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH_WORDS];
    logic [7:0] lane_rd_reg;

    always_ff @(posedge clk_i) begin
      if (en) begin
        if (we && be[gi]) begin
          lane_mem[addr] <= wdata[gi*8 +: 8];
        end
        lane_rd_reg <= lane_mem[addr];
      end
    end

    assign rdata[gi*8 +: 8] = lane_rd_reg;
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder: one access at a time over req/ack, with wait states,
// byte-enable stores, error responses and the core-facing stall signal.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int                DEPTH_WORDS = 1024,
  parameter int                LATENCY     = 3,
  parameter logic [WORD_W-1:0] RESET_RDATA = RESET_RDATA_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic [31:0]       addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o,
  output logic              ack_o,
  output logic              err_o,
  output logic              stall_o,
  output logic              busy_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = (LATENCY > 0) ? CW'(LATENCY - 1) : '0;

  state_t            state_reg;
  logic [CW-1:0]     cnt_reg;
  logic              we_reg;
  logic [BE_W-1:0]   be_reg;
  logic [AW-1:0]     addr_reg;
  logic [WORD_W-1:0] wdata_reg;
  logic              ack_reg;
  logic              err_reg;

  logic              req_bad;
  logic              accept;
  logic              use_live;
  logic              ram_en;
  logic              ram_we;
  logic [BE_W-1:0]   ram_be;
  logic [AW-1:0]     ram_addr;
  logic [WORD_W-1:0] ram_wdata;
  logic [WORD_W-1:0] ram_rdata;

  assign req_bad  = is_invalid(addr_i, we_i, be_i, 32'(DEPTH_WORDS));
  assign accept   = (state_reg == IDLE) && req_i;
  assign use_live = (state_reg == IDLE);

  // The array is touched only on the edge entering RESP. With zero latency that
  // edge is the acceptance edge, so the live inputs feed the array directly.
  // Gating with reset keeps an aborted access from committing.
  assign ram_en    = rst_i &&
                     ((accept && !req_bad && (LATENCY == 0)) ||
                      ((state_reg == WAIT) && (cnt_reg == '0)));
  assign ram_we    = use_live ? we_i             : we_reg;
  assign ram_be    = use_live ? be_i             : be_reg;
  assign ram_addr  = use_live ? addr_i[AW+1:2]   : addr_reg;
  assign ram_wdata = use_live ? wdata_i          : wdata_reg;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk_i (clk_i),
    .en    (ram_en),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      we_reg    <= 1'b0;
      be_reg    <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      ack_reg <= 1'b0;
      err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_i) begin
            we_reg    <= we_i;
            be_reg    <= be_i;
            addr_reg  <= addr_i[AW+1:2];
            wdata_reg <= wdata_i;
            if (req_bad) begin
              state_reg <= RESP;
              ack_reg   <= 1'b1;
              err_reg   <= 1'b1;
            end else if (LATENCY > 0) begin
              state_reg <= WAIT;
              cnt_reg   <= CNT_INIT;
            end else begin
              state_reg <= RESP;
              ack_reg   <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (cnt_reg == '0) begin
            state_reg <= RESP;
            ack_reg   <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        RESP: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign ack_o   = ack_reg;
  assign err_o   = err_reg;
  assign rdata_o = (ack_reg && !err_reg && !we_reg) ? ram_rdata : RESET_RDATA;
  assign stall_o = req_i & ~ack_o;
  assign busy_o  = (state_reg != IDLE);

endmodule
